fullchip_inst_seq: RTL and testbench
====================================

FULLCHIP_INST_SEQ -- requirements
Module: fullchip_inst_seq

Interface
REQ-001 SHALL have parameter BW, default 8, meaning Q/K element bit width.
REQ-002 SHALL have parameter PR, default 16, meaning elements per vector; the data path is PR*BW wide.
REQ-003 SHALL have parameter COL, default 8, meaning K vectors (dot-product columns).
REQ-004 SHALL have parameter QDEPTH, default 16, meaning the maximum Q vectors per run; ADDR_W = clog2(QDEPTH), minimum 1.
REQ-005 SHALL have parameter GAP, default 10, meaning idle cycles after K load and after execute.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begin a run (sampled in IDLE only).
REQ-009 SHALL have port num_q, input, ADDR_W+1 bits: Q vectors this run (1..QDEPTH), latched at start.
REQ-010 SHALL have port skip_k, input, 1 bit: reuse the resident K, skipping K write and K load; latched at start.
REQ-011 SHALL have port din, input, PR*BW bits: host Q/K vector.
REQ-012 SHALL have port din_valid, input, 1 bit, and port din_ready, output, 1 bit: the host handshake.
REQ-013 SHALL have port mem_in, output, PR*BW bits: the registered vector to the core.
REQ-014 SHALL have port inst, output, 2*ADDR_W+9 bits: {ofifo_rd, qkmem_add, pmem_add, execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}, MSB first.
REQ-015 SHALL have ports busy and done, output, 1 bit each: busy is high outside IDLE; done is a 1-cycle pulse at run end.

Function
REQ-016 SHALL sequence these states: IDLE, QWR, KWR, GAP0, KLOAD, WAIT1, EXEC, WAIT2, DRAIN, DONE.
REQ-017 SHALL, in IDLE, move to QWR on start with 1<=num_q<=QDEPTH; start with num_q=0 or num_q>QDEPTH SHALL be ignored.
REQ-018 SHALL drive din_ready high only in QWR and KWR; an accepted beat is din_valid&&din_ready.
REQ-019 SHALL, in QWR, on beat n (n=0..num_q-1), register mem_in=din, qmem_wr=1, qkmem_add=n in the next cycle; a non-accept cycle SHALL register an all-zero inst.
REQ-020 SHALL leave QWR after beat num_q-1, going to KWR, or to WAIT1 when skip_k=1.
REQ-021 SHALL, in KWR, behave as in QWR with kmem_wr and COL beats, then go to GAP0.
REQ-022 SHALL hold GAP0 for 2 cycles with inst=0.
REQ-023 SHALL run KLOAD for COL+2 cycles (c=0..COL+1) with load=1 throughout.
REQ-024 SHALL, in KLOAD, drive kmem_rd=1 and qkmem_add=c-1 for c=1..COL; at c=0 and c=COL+1, kmem_rd=0 and qkmem_add=0.
REQ-025 SHALL hold WAIT1 and WAIT2 for GAP cycles each with inst=0.
REQ-026 SHALL, in EXEC, drive execute=1, qmem_rd=1, qkmem_add=c for c=0..num_q-1.
REQ-027 SHALL, in DRAIN, drive ofifo_rd=1, pmem_wr=1, pmem_add=c for c=0..num_q-1.
REQ-028 SHALL pulse done in DONE for 1 cycle, then return to IDLE.
REQ-029 SHALL register inst and mem_in, so they change one cycle after the state/counter decision.
REQ-030 SHALL hold mem_in at its last value outside accepted beats.
REQ-031 SHALL ignore start while busy; num_q and skip_k changes mid-run SHALL have no effect.
REQ-032 SHALL keep pmem_rd always 0.

Reset
REQ-033 SHALL, on reset, force state=IDLE, all counters=0, inst=0, mem_in=0, din_ready=0, busy=0, done=0, regardless of the current state.

Configuration
REQ-034 SHALL, with macro FULLCHIP_SEQ_ABORT_EN defined, add input abort (1 bit); abort=1 in any non-IDLE state SHALL zero inst next cycle, return to IDLE, and pulse no done; without the macro there is no port and no such behaviour.

Structure
REQ-035 SHALL take the state enum, inst bit-position constants and the ADDR_W function from package fullchip_seq_pkg.
REQ-036 SHALL place inst field packing in sub-module fullchip_seq_inst_pack (combinational), instantiated once.

Verification
REQ-037 SHALL cover defaults, num_q=8, skip_k=0, din_valid always high -> 8 qmem_wr beats at add 0..7, 8 kmem_wr beats, 10 KLOAD cycles, 8 EXEC, 8 DRAIN, done once; total cycles checked.
REQ-038 SHALL cover skip_k=1, num_q=4 -> no kmem_wr or load asserted; EXEC qkmem_add 0..3; DRAIN pmem_add 0..3.
REQ-039 SHALL cover din_valid toggling 1,0,1,0 in QWR -> qmem_wr only after valid cycles, addresses contiguous, zero inst in gaps.
REQ-040 SHALL cover num_q=0 with start, and num_q=17 with QDEPTH=16 -> busy stays 0, inst stays 0.
REQ-041 SHALL cover reset asserted in cycle 3 of EXEC -> inst=0 and busy=0 the next cycle; a fresh start then works.
REQ-042 SHALL cover, with FULLCHIP_SEQ_ABORT_EN, abort in DRAIN -> IDLE with no done pulse.

Source files
------------

// File: rtl/fullchip_seq_pkg.sv
// fullchip_seq_pkg: shared state encoding, inst bit map and sizing helpers
// for the fullchip instruction sequencer (optional macro FULLCHIP_SEQ_ABORT_EN).
package fullchip_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_QWR,
        S_KWR,
        S_GAP0,
        S_KLOAD,
        S_WAIT1,
        S_EXEC,
        S_WAIT2,
        S_DRAIN,
        S_DONE
    } state_e;

    // Low inst flag bits; the two address fields and ofifo_rd sit above them.
    localparam int PMEM_WR_B = 0;
    localparam int PMEM_RD_B = 1;
    localparam int KMEM_WR_B = 2;
    localparam int KMEM_RD_B = 3;
    localparam int QMEM_WR_B = 4;
    localparam int QMEM_RD_B = 5;
    localparam int LOAD_B    = 6;
    localparam int EXECUTE_B = 7;
    localparam int FLAG_W    = 8;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int inst_w(input int aw);
        return 2 * aw + FLAG_W + 1;
    endfunction

endpackage

// File: rtl/fullchip_seq_inst_pack.sv
// fullchip_seq_inst_pack: packs the sequencer control fields into the
// inst word {ofifo_rd, qkmem_add, pmem_add, flags}, MSB first.
module fullchip_seq_inst_pack
    import fullchip_seq_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                           ofifo_rd_i,
    input  logic [ADDR_W-1:0]              qkmem_add_i,
    input  logic [ADDR_W-1:0]              pmem_add_i,
    input  logic [FLAG_W-1:0]              flags_i,
    output logic [2*ADDR_W+FLAG_W:0]       inst_o
);

    assign inst_o = {ofifo_rd_i, qkmem_add_i, pmem_add_i, flags_i};

endmodule

// File: rtl/fullchip_inst_seq.sv
// fullchip_inst_seq: Q/K write, K load, execute and drain sequencer.
// Define FULLCHIP_SEQ_ABORT_EN to add the abort input.
module fullchip_inst_seq
    import fullchip_seq_pkg::*;
#(
    parameter  int BW     = 8,
    parameter  int PR     = 16,
    parameter  int COL    = 8,
    parameter  int QDEPTH = 16,
    parameter  int GAP    = 10,
    localparam int ADDR_W = addr_w(QDEPTH),
    localparam int IW     = inst_w(ADDR_W)
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef FULLCHIP_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [ADDR_W:0]      num_q,
    input  logic                 skip_k,
    input  logic [PR*BW-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [PR*BW-1:0]     mem_in,
    output logic [IW-1:0]        inst,
    output logic                 busy,
    output logic                 done
);

    localparam int M1      = (QDEPTH > COL + 2) ? QDEPTH : COL + 2;
    localparam int CNT_MAX = (M1 > GAP) ? M1 : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W:0]  QMAX   = (ADDR_W+1)'(QDEPTH);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_KW   = CNT_W'(COL - 1);
    localparam logic [CNT_W-1:0] C_KL   = CNT_W'(COL + 1);
    localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W:0]     nq_q, nq_d;
    logic                skip_q, skip_d;
    logic [PR*BW-1:0]    mem_q, mem_d;
    logic [IW-1:0]       inst_q, inst_d;

    logic                ofifo;
    logic [ADDR_W-1:0]   qk_add, pm_add;
    logic [FLAG_W-1:0]   flags;
    logic [CNT_W-1:0]    nq_last;
    logic                beat;
    logic                abort_w;

`ifdef FULLCHIP_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign din_ready = (state_q == S_QWR) || (state_q == S_KWR);
    assign beat      = din_valid && din_ready;
    assign nq_last   = CNT_W'(nq_q) - C_ONE;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) && !abort_w;
    assign mem_in    = mem_q;
    assign inst      = inst_q;

    fullchip_seq_inst_pack #(.ADDR_W(ADDR_W)) u_pack (
        .ofifo_rd_i  (ofifo),
        .qkmem_add_i (qk_add),
        .pmem_add_i  (pm_add),
        .flags_i     (flags),
        .inst_o      (inst_d)
    );

    // Next state, phase counter and the control fields for next cycle's inst.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        skip_d  = skip_q;
        mem_d   = mem_q;
        ofifo   = 1'b0;
        qk_add  = '0;
        pm_add  = '0;
        flags   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (num_q != '0) && (num_q <= QMAX)) begin
                    state_d = S_QWR;
                    cnt_d   = '0;
                    nq_d    = num_q;
                    skip_d  = skip_k;
                end
            end
            S_QWR: begin
                if (beat) begin
                    flags[QMEM_WR_B] = 1'b1;
                    qk_add = ADDR_W'(cnt_q);
                    mem_d  = din;
                    if (cnt_q == nq_last) begin
                        cnt_d   = '0;
                        state_d = skip_q ? S_WAIT1 : S_KWR;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
            S_KWR: begin
                if (beat) begin
                    flags[KMEM_WR_B] = 1'b1;
                    qk_add = ADDR_W'(cnt_q);
                    mem_d  = din;
                    if (cnt_q == C_KW) begin
                        cnt_d   = '0;
                        state_d = S_GAP0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
            S_GAP0: begin
                if (cnt_q == C_ONE) begin
                    cnt_d   = '0;
                    state_d = S_KLOAD;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_KLOAD: begin
                flags[LOAD_B] = 1'b1;
                if ((cnt_q != '0) && (cnt_q != C_KL)) begin
                    flags[KMEM_RD_B] = 1'b1;
                    qk_add = ADDR_W'(cnt_q - C_ONE);
                end
                if (cnt_q == C_KL) begin
                    cnt_d   = '0;
                    state_d = S_WAIT1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_WAIT1, S_WAIT2: begin
                if (cnt_q == C_GAP) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_WAIT1) ? S_EXEC : S_DRAIN;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_EXEC: begin
                flags[EXECUTE_B] = 1'b1;
                flags[QMEM_RD_B] = 1'b1;
                qk_add = ADDR_W'(cnt_q);
                if (cnt_q == nq_last) begin
                    cnt_d   = '0;
                    state_d = S_WAIT2;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_DRAIN: begin
                ofifo = 1'b1;
                flags[PMEM_WR_B] = 1'b1;
                pm_add = ADDR_W'(cnt_q);
                if (cnt_q == nq_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_w && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            mem_d   = mem_q;
            ofifo   = 1'b0;
            qk_add  = '0;
            pm_add  = '0;
            flags   = '0;
        end
    end

    // State, counters and the registered core-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nq_q    <= '0;
            skip_q  <= 1'b0;
            mem_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            skip_q  <= skip_d;
            mem_q   <= mem_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// tb_fullchip_inst_seq: randomized scoreboard bench for fullchip_inst_seq.
// Honours FULLCHIP_SEQ_ABORT_EN for the abort scenario.
module tb_fullchip_inst_seq;

    localparam int BW = 8, PR = 16, COL = 8, QDEPTH = 16, GAP = 10;
    localparam int AW = 4, IW = 2 * AW + 9, DW = PR * BW;

    localparam int F_PWR  = 1;
    localparam int F_KWR  = 4;
    localparam int F_KRD  = 8;
    localparam int F_QWR  = 16;
    localparam int F_QRD  = 32;
    localparam int F_LOAD = 64;
    localparam int F_EXE  = 128;

    logic clk = 1'b0;
    logic reset, start, skip_k, din_valid;
    logic [AW:0] num_q;
    logic [DW-1:0] din, mem_in;
    logic [IW-1:0] inst;
    logic din_ready, busy, done;
    logic abort;

    fullchip_inst_seq #(
        .BW(BW), .PR(PR), .COL(COL), .QDEPTH(QDEPTH), .GAP(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef FULLCHIP_SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .num_q(num_q),
        .skip_k(skip_k),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .mem_in(mem_in),
        .inst(inst),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int            e;
        logic [IW-1:0] ins;
        logic [DW-1:0] mem;
        bit            wr;
    } ev_t;

    ev_t sb[$];
    int  done_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    logic [DW-1:0] last_wr;

    function automatic logic [IW-1:0] mk(int fl, int qk, int pm, bit of);
        logic [IW-1:0] v;
        logic [31:0] f32, q32, p32;
        f32 = fl; q32 = qk; p32 = pm;
        v = '0;
        v[7:0]   = f32[7:0];
        v[11:8]  = p32[3:0];
        v[15:12] = q32[3:0];
        v[16]    = of;
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     nm, act, exp, edge_cnt);
        end
    endtask

    task automatic push(int e, logic [IW-1:0] v, logic [DW-1:0] m, bit wr);
        ev_t ev;
        ev.e = e; ev.ins = v; ev.mem = m; ev.wr = wr;
        sb.push_back(ev);
    endtask

    // Monitor: every nonzero inst and every done pulse is matched in order.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (mon_en && inst !== '0) begin
                if (sb.size() == 0) begin
                    chk("extra_inst", DW'(inst), '0);
                end else begin
                    ev = sb.pop_front();
                    chk("inst_edge", DW'(edge_cnt), DW'(ev.e));
                    chk("inst", DW'(inst), DW'(ev.ins));
                    if (ev.wr) chk("mem_in", mem_in, ev.mem);
                end
            end
            if (mon_en && done === 1'b1) begin
                if (done_q.size() == 0) chk("extra_done", DW'(done), '0);
                else chk("done_edge", DW'(edge_cnt), DW'(done_q.pop_front()));
            end
        end
    end

    // One host write phase of cnt beats; valid pattern by mode.
    task automatic wr_phase(int cnt, int fl, int mode);
        int n, i;
        bit v;
        n = 0; i = 0;
        while (n < cnt) begin
            v = (mode == 0) ? 1'b1 :
                (mode == 1) ? (i % 2 == 0) : ($urandom_range(3) != 0);
            din_valid = v;
            din = rnd_vec();
            if (v) begin
                push(edge_cnt + 1, mk(fl, n, 0, 0), din, 1'b1);
                last_wr = din;
                n++;
            end
            i++;
            @(negedge clk);
        end
    endtask

    // cut: 0 full run, 1 reset in 3rd EXEC cycle, 2 abort in 2nd DRAIN cycle.
    task automatic run(int nq, bit skip, int mode, int cut);
        int e, xs, ds, last, r;
        start = 1'b1; num_q = (AW+1)'(nq); skip_k = skip; din_valid = 1'b0;
        @(negedge clk);
        num_q = (AW+1)'($urandom); skip_k = 1'($urandom);
        wr_phase(nq, F_QWR, mode);
        if (!skip) wr_phase(COL, F_KWR, mode);
        start = 1'b0;
        din_valid = 1'b1;
        din = rnd_vec();
        e = edge_cnt + 1;
        xs = skip ? e + GAP : e + 2 + COL + 2 + GAP;
        ds = xs + nq + GAP;
        last = ds + nq - 1;
        r = (cut == 1) ? xs + 2 : (cut == 2) ? ds + 1 : last + 2;
        if (!skip) begin
            for (int c = 0; c < COL + 2; c++) begin
                if (c >= 1 && c <= COL) push(e + 2 + c, mk(F_LOAD | F_KRD, c - 1, 0, 0), '0, 1'b0);
                else push(e + 2 + c, mk(F_LOAD, 0, 0, 0), '0, 1'b0);
            end
        end
        for (int c = 0; c < nq; c++)
            if (xs + c < r) push(xs + c, mk(F_EXE | F_QRD, c, 0, 0), '0, 1'b0);
        for (int c = 0; c < nq; c++)
            if (ds + c < r) push(ds + c, mk(F_PWR, 0, c, 1'b1), '0, 1'b0);
        if (cut == 0) done_q.push_back(last);
        if (cut != 0) begin
            while (edge_cnt < r - 1) @(negedge clk);
            if (cut == 1) reset = 1'b1;
            else abort = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            abort = 1'b0;
            chk("cut_inst", DW'(inst), '0);
            chk("cut_busy", DW'(busy), '0);
            chk("cut_done", DW'(done), '0);
            chk("cut_sb_empty", DW'(sb.size()), '0);
            @(negedge clk);
            chk("cut_no_done", DW'(done), '0);
        end else begin
            while (edge_cnt < last + 1) @(negedge clk);
            chk("end_busy", DW'(busy), '0);
            chk("end_mem_hold", mem_in, last_wr);
            chk("end_sb_empty", DW'(sb.size()), '0);
            chk("end_done_seen", DW'(done_q.size()), '0);
        end
        din_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic bad_start(int nq);
        start = 1'b1; num_q = (AW+1)'(nq); skip_k = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            chk("bad_busy", DW'(busy), '0);
            chk("bad_inst", DW'(inst), '0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_q = '0; skip_k = 1'b0;
        din = '0; din_valid = 1'b0; abort = 1'b0; last_wr = '0;
        repeat (3) @(negedge clk);
        chk("rst_inst", DW'(inst), '0);
        chk("rst_mem_in", mem_in, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_din_ready", DW'(din_ready), '0);
        chk("rst_done", DW'(done), '0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        run(8, 1'b0, 0, 0);
        run(4, 1'b1, 0, 0);
        run(4, 1'b1, 1, 0);
        run(5, 1'b0, 1, 0);
        bad_start(0);
        bad_start(17);
        run(8, 1'b0, 0, 1);
        run(5, 1'b0, 2, 0);
`ifdef FULLCHIP_SEQ_ABORT_EN
        run(6, 1'b1, 0, 2);
        run(3, 1'b0, 0, 0);
`endif
        for (int k = 0; k < 5; k++)
            run($urandom_range(1, QDEPTH), 1'($urandom), 2, 0);
        run(QDEPTH, 1'b0, 0, 0);
        run(1, 1'b1, 0, 0);
        repeat (5) @(negedge clk);
        chk("final_sb_empty", DW'(sb.size()), '0);
        chk("final_done_q_empty", DW'(done_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
